ipf_lcu_scheduler: RTL

IPF_LCU_SCHEDULER -- requirements
Module: ipf_lcu_scheduler

---
 rtl/ipf_pkg.sv | 50 +++++
 rtl/ipf_addr_gen.sv | 68 ++++++
 rtl/ipf_lcu_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ipf_pkg.sv
// Shared types and helpers for the in-loop filter LCU scheduler.
package ipf_pkg;

    localparam int unsigned IMG_W_DEF = 128;
    localparam int unsigned PIX_W     = 6;

    typedef enum logic [1:0] {
        LCU_16  = 2'd0,
        LCU_32  = 2'd1,
        LCU_64  = 2'd2,
        LCU_RSV = 2'd3
    } lcu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [1:0]  ftype;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } lcu_prm_t;

    // The reserved encoding behaves as the smallest LCU.
    function automatic logic [1:0] lcu_norm(input logic [1:0] code);
        return (lcu_size_e'(code) == LCU_RSV) ? 2'(LCU_16) : code;
    endfunction

    function automatic logic [2:0] lcu_shift(input logic [1:0] code);
        case (lcu_size_e'(code))
            LCU_32:  return 3'd5;
            LCU_64:  return 3'd6;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] lcu_max(input logic [1:0] code);
        case (lcu_size_e'(code))
            LCU_32:  return PIX_W'(31);
            LCU_64:  return PIX_W'(63);
            default: return PIX_W'(15);
        endcase
    endfunction

endpackage

// File: rtl/ipf_addr_gen.sv
// Pixel/LCU raster counters and image address for the LCU scheduler.
module ipf_addr_gen
    import ipf_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          step,
    input  logic [1:0]                    size,
    output logic [2*$clog2(IMG_W)-1:0]    addr,
    output logic [$clog2(IMG_W)-5:0]      lcu_x,
    output logic [$clog2(IMG_W)-5:0]      lcu_y,
    output logic                          last_pix,
    output logic                          last_lcu
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned LW = CW - 4;

    logic [PIX_W-1:0] col;
    logic [PIX_W-1:0] row;
    logic [PIX_W-1:0] size_m1;
    logic [LW-1:0]    lcu_last;
    logic [2:0]       shift;
    logic [CW-1:0]    x_pos;
    logic [CW-1:0]    y_pos;

    always_comb begin
        shift    = lcu_shift(size);
        size_m1  = lcu_max(size);
        lcu_last = LW'((IMG_W >> shift) - 1);
        x_pos    = (CW'(lcu_x) << shift) | CW'(col);
        y_pos    = (CW'(lcu_y) << shift) | CW'(row);
        addr     = {y_pos, x_pos};
        last_pix = (col == size_m1) && (row == size_m1);
        last_lcu = (lcu_x == lcu_last) && (lcu_y == lcu_last);
    end

    // Column fastest, then row, then lcu_x, then lcu_y; wraps to zero after the image.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            col   <= '0;
            row   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (step) begin
            if (col == size_m1) begin
                col <= '0;
                if (row == size_m1) begin
                    row <= '0;
                    if (lcu_x == lcu_last) begin
                        lcu_x <= '0;
                        lcu_y <= (lcu_y == lcu_last) ? '0 : lcu_y + LW'(1);
                    end else begin
                        lcu_x <= lcu_x + LW'(1);
                    end
                end else begin
                    row <= row + PIX_W'(1);
                end
            end else begin
                col <= col + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ipf_lcu_scheduler.sv
// Walks the image LCU by LCU, streams pixels to the filter with a one-entry skid.
// Optional stall counter output enabled by defining IPF_SCHED_PERF_CNT_EN.
module ipf_lcu_scheduler
    import ipf_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    cfg_lcu_size,
    input  logic                          prm_valid,
    output logic                          prm_ready,
    input  logic [1:0]                    prm_type,
    input  logic [4:0]                    prm_band_pos,
    input  logic                          prm_wo_class,
    input  logic [15:0]                   prm_offset,
    output logic                          mem_rd,
    output logic [2*$clog2(IMG_W)-1:0]    mem_addr,
    input  logic [7:0]                    mem_data,
    input  logic                          ipf_busy,
    output logic                          ipf_in_en,
    output logic [7:0]                    ipf_din,
    output logic [1:0]                    ipf_type,
    output logic [4:0]                    ipf_band_pos,
    output logic                          ipf_wo_class,
    output logic [15:0]                   ipf_offset,
    output logic [$clog2(IMG_W)-5:0]      lcu_x,
    output logic [$clog2(IMG_W)-5:0]      lcu_y,
    output logic [1:0]                    lcu_size,
    output logic                          done
`ifdef IPF_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int unsigned LW = $clog2(IMG_W) - 4;

    state_e        state;
    state_e        state_next;
    lcu_prm_t      prm_q;
    logic          rd_pend;
    logic          skid_vld;
    logic [7:0]    skid_data;
    logic          final_lcu;
    logic          ag_clear;
    logic [LW-1:0] ag_lcu_x;
    logic [LW-1:0] ag_lcu_y;
    logic          ag_last_pix;
    logic          ag_last_lcu;

    ipf_addr_gen #(
        .IMG_W (IMG_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (ag_clear),
        .step     (mem_rd),
        .size     (lcu_size),
        .addr     (mem_addr),
        .lcu_x    (ag_lcu_x),
        .lcu_y    (ag_lcu_y),
        .last_pix (ag_last_pix),
        .last_lcu (ag_last_lcu)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // mem_rd and the pixel stream react to ipf_busy in the same cycle, so they are decoded here.
    always_comb begin
        state_next = state;
        ag_clear   = 1'b0;
        mem_rd     = 1'b0;
        ipf_in_en  = 1'b0;
        ipf_din    = '0;

        if (!ipf_busy && skid_vld) begin
            ipf_in_en = 1'b1;
            ipf_din   = skid_data;
        end else if (!ipf_busy && rd_pend) begin
            ipf_in_en = 1'b1;
            ipf_din   = mem_data;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    ag_clear   = 1'b1;
                    state_next = ST_PARAM;
                end
            end
            ST_PARAM: begin
                if (prm_valid && prm_ready) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd = !ipf_busy && !skid_vld;
                if (mem_rd && ag_last_pix) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Reads are in order and skid/pending are exclusive, so any delivery here is the last one.
                if (ipf_in_en) state_next = final_lcu ? ST_DONE : ST_PARAM;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prm_ready <= 1'b0;
            done      <= 1'b0;
            lcu_size  <= '0;
            prm_q     <= '0;
            lcu_x     <= '0;
            lcu_y     <= '0;
            final_lcu <= 1'b0;
            rd_pend   <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else begin
            prm_ready <= (state_next == ST_PARAM);
            done      <= (state_next == ST_DONE);
            rd_pend   <= mem_rd;
            if (ag_clear) lcu_size <= lcu_norm(cfg_lcu_size);
            // Counters already point at the LCU about to be fetched when its parameters arrive.
            if (prm_valid && prm_ready) begin
                prm_q <= '{ftype: prm_type, band_pos: prm_band_pos,
                           wo_class: prm_wo_class, offset: prm_offset};
                lcu_x <= ag_lcu_x;
                lcu_y <= ag_lcu_y;
            end
            if (mem_rd && ag_last_pix) final_lcu <= ag_last_lcu;
            if (rd_pend && ipf_busy) begin
                skid_vld  <= 1'b1;
                skid_data <= mem_data;
            end else if (skid_vld && !ipf_busy) begin
                skid_vld  <= 1'b0;
            end
        end
    end

    assign ipf_type     = prm_q.ftype;
    assign ipf_band_pos = prm_q.band_pos;
    assign ipf_wo_class = prm_q.wo_class;
    assign ipf_offset   = prm_q.offset;

`ifdef IPF_SCHED_PERF_CNT_EN
    // Saturating count of back-pressured cycles while the LCU datapath is active.
    always_ff @(posedge clk) begin
        if (!reset || ag_clear) begin
            stall_cnt <= '0;
        end else if ((state == ST_FETCH || state == ST_DRAIN) && ipf_busy
                     && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
